// File: rtl/hmmm_boot_loader.sv
// UART program loader for the HMMM SRAM: holds the CPU in reset while
// writing the received image, then passes the SRAM pins through to the CPU.
module hmmm_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  cpu_memwrite,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  output logic                  cpu_reset,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_doe,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } u_state_t;

  typedef enum logic [3:0] {
    S_COUNT, S_RX_HI, S_RX_LO, S_WR_SETUP,
    S_WR_P1, S_WR_P2, S_WR_HOLD, S_DONE, S_ERROR
  } m_state_t;

  u_state_t        r_u_q, w_u_d;
  m_state_t        r_s_q, w_s_d;
  logic            r_rx_s1, r_rx_s2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_bv, r_fe;
  logic [7:0]      r_hold;
  logic            r_full;
  logic [8:0]      r_remain;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_word;
  logic            w_rx, w_half, w_full;
  logic            w_take, w_live, w_ovr;

  assign w_rx   = r_rx_s2;
  assign w_half = (r_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_u_q <= U_IDLE;
    else       r_u_q <= w_u_d;
  end

  always_comb begin
    w_u_d = r_u_q;
    unique case (r_u_q)
      U_IDLE:  if (!w_rx) w_u_d = U_START;
      U_START: if (w_half) w_u_d = w_rx ? U_IDLE : U_DATA;
      U_DATA:  if (w_full && r_idx == 3'd7) w_u_d = U_STOP;
      U_STOP:  if (w_full) w_u_d = U_IDLE;
      default: w_u_d = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_bv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_bv <= (r_u_q == U_STOP) && w_full && w_rx;
      r_fe <= (r_u_q == U_STOP) && w_full && !w_rx;
      unique case (r_u_q)
        U_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
        U_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        U_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP:  r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Bytes are only accepted before the hand-over; afterwards the line is ignored
  assign w_live = (r_s_q != S_DONE) && (r_s_q != S_ERROR);
  assign w_take = r_full &&
                  (r_s_q == S_COUNT || r_s_q == S_RX_HI || r_s_q == S_RX_LO);
  assign w_ovr  = r_bv && r_full && !w_take && w_live;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_take) r_full <= 1'b0;
      if (r_bv && w_live) begin
        r_hold <= r_shift;
        r_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_s_q <= S_COUNT;
    else       r_s_q <= w_s_d;
  end

  always_comb begin
    w_s_d = r_s_q;
    unique case (r_s_q)
      S_COUNT:    if (r_full) w_s_d = S_RX_HI;
      S_RX_HI:    if (r_full) w_s_d = S_RX_LO;
      S_RX_LO:    if (r_full) w_s_d = S_WR_SETUP;
      S_WR_SETUP: w_s_d = S_WR_P1;
      S_WR_P1:    w_s_d = S_WR_P2;
      S_WR_P2:    w_s_d = S_WR_HOLD;
      S_WR_HOLD:  w_s_d = (r_remain == 9'd1) ? S_DONE : S_RX_HI;
      S_DONE:     w_s_d = S_DONE;
      S_ERROR:    w_s_d = S_ERROR;
      default:    w_s_d = S_ERROR;
    endcase
    if (w_live && (r_fe || w_ovr)) w_s_d = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain <= '0;
      r_addr   <= '0;
      r_word   <= '0;
    end else begin
      unique case (r_s_q)
        S_COUNT: if (r_full) begin
          r_remain <= (r_hold == 8'd0) ? 9'd256 : {1'b0, r_hold};
          r_addr   <= '0;
        end
        S_RX_HI: if (r_full) r_word[DATA_WIDTH-1 -: 8] <= r_hold;
        S_RX_LO: if (r_full) r_word[7:0] <= r_hold;
        S_WR_HOLD: begin
          r_addr   <= r_addr + 1'b1;
          r_remain <= r_remain - 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    sram_ce_n = 1'b0;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_doe  = 1'b0;
    sram_adr  = r_addr;
    sram_dout = r_word;
    unique case (r_s_q)
      S_WR_SETUP, S_WR_HOLD: sram_doe = 1'b1;
      S_WR_P1, S_WR_P2: begin
        sram_doe  = 1'b1;
        sram_we_n = 1'b0;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        sram_we_n = ~cpu_memwrite;
        sram_oe_n = cpu_memwrite;
        sram_adr  = cpu_adr;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule
